// File: rtl/ula_estagio_saida.sv
// ula_estagio_saida: output stage of the 16-bit ALU.
// Captures each ALU result and computes the Z/C/N/O status flags.
// Results go through a 2-entry in-order FIFO toward writeback.
// The flags live in an architectural status register.
module ula_estagio_saida #(
    parameter int bits_palavra  = 16,
    parameter int bits_controle = 5,
    parameter int bits_reg      = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [bits_palavra-1:0]  operandoA,
    input  logic [bits_palavra-1:0]  operandoB,
    input  logic [bits_controle-1:0] controle,
    input  logic [bits_palavra-1:0]  resultadoOp,
    input  logic [bits_reg-1:0]      regDestino,
    input  logic                     atualizaFlags,
    input  logic                     valido_in,
    output logic                     pronto_in,
    input  logic                     descarta,
    output logic [bits_palavra-1:0]  resultado,
    output logic [bits_reg-1:0]      regDestino_out,
    output logic                     valido_out,
    input  logic                     pronto_out,
    output logic                     flagZ,
    output logic                     flagC,
    output logic                     flagN,
    output logic                     flagO
);

    localparam logic [bits_controle-1:0] OP_ADD    = bits_controle'(0);
    localparam logic [bits_controle-1:0] OP_ADDC   = bits_controle'(1);
    localparam logic [bits_controle-1:0] OP_INC    = bits_controle'(3);
    localparam logic [bits_controle-1:0] OP_SUBB   = bits_controle'(4);
    localparam logic [bits_controle-1:0] OP_SUB    = bits_controle'(5);
    localparam logic [bits_controle-1:0] OP_DEC    = bits_controle'(6);
    localparam logic [bits_controle-1:0] OP_SHL    = bits_controle'(8);
    localparam logic [bits_controle-1:0] OP_SHR    = bits_controle'(9);

    localparam logic [bits_palavra:0]    UM_EXT    = (bits_palavra+1)'(1);
    localparam logic [bits_palavra-1:0]  MAX_POS   = {1'b0, {(bits_palavra-1){1'b1}}};
    localparam logic [bits_palavra-1:0]  MIN_NEG   = {1'b1, {(bits_palavra-1){1'b0}}};

    // FIFO state: slot 0 is always the head
    logic [1:0]              contagem;
    logic [bits_palavra-1:0] dado0, dado1;
    logic [bits_reg-1:0]     reg0, reg1;

    logic aceita, retira;

    // Flag next-state values and the carry-producing sums
    logic [bits_palavra:0] soma_ab, soma_ab1, soma_anb, soma_anb1;
    logic z_prox, c_prox, n_prox, o_prox;
    logic sinal_a, sinal_b, sinal_r;

    assign pronto_in      = (contagem != 2'd2);
    assign valido_out     = (contagem != 2'd0);
    assign resultado      = dado0;
    assign regDestino_out = reg0;
    assign aceita         = valido_in && pronto_in;
    assign retira         = valido_out && pronto_out;

    assign sinal_a = operandoA[bits_palavra-1];
    assign sinal_b = operandoB[bits_palavra-1];
    assign sinal_r = resultadoOp[bits_palavra-1];

    assign soma_ab   = {1'b0, operandoA} + {1'b0, operandoB};
    assign soma_ab1  = {1'b0, operandoA} + {1'b0, operandoB} + UM_EXT;
    assign soma_anb  = {1'b0, operandoA} + {1'b0, ~operandoB};
    assign soma_anb1 = {1'b0, operandoA} + {1'b0, ~operandoB} + UM_EXT;

    // Status flags derived from the ALU operands, result and operation code
    always_comb begin
        z_prox = (resultadoOp == '0);
        n_prox = sinal_r;
        c_prox = 1'b0;
        o_prox = 1'b0;
        case (controle)
            OP_ADD: begin
                c_prox = soma_ab[bits_palavra];
                o_prox = (sinal_a == sinal_b) && (sinal_r != sinal_a);
            end
            OP_ADDC: begin
                c_prox = soma_ab1[bits_palavra];
                o_prox = (sinal_a == sinal_b) && (sinal_r != sinal_a);
            end
            OP_INC: begin
                c_prox = &operandoA;
                o_prox = (operandoA == MAX_POS);
            end
            OP_SUBB: begin
                c_prox = soma_anb[bits_palavra];
                o_prox = (sinal_a != sinal_b) && (sinal_r != sinal_a);
            end
            OP_SUB: begin
                c_prox = soma_anb1[bits_palavra];
                o_prox = (sinal_a != sinal_b) && (sinal_r != sinal_a);
            end
            OP_DEC: begin
                c_prox = |operandoA;
                o_prox = (operandoA == MIN_NEG);
            end
            OP_SHL: begin
                c_prox = sinal_a;
                o_prox = sinal_a ^ operandoA[bits_palavra-2];
            end
            OP_SHR: begin
                c_prox = operandoA[0];
            end
            default: begin
                c_prox = 1'b0;
                o_prox = 1'b0;
            end
        endcase
    end

    // Status register: loads on a flagged accept, even when the FIFO is flushed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flagZ <= 1'b0;
            flagC <= 1'b0;
            flagN <= 1'b0;
            flagO <= 1'b0;
        end else if (aceita && atualizaFlags) begin
            flagZ <= z_prox;
            flagC <= c_prox;
            flagN <= n_prox;
            flagO <= o_prox;
        end
    end

    // Two-entry FIFO; flush wins over push and pop, new entries queue behind the head
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contagem <= 2'd0;
            dado0    <= '0;
            dado1    <= '0;
            reg0     <= '0;
            reg1     <= '0;
        end else if (descarta) begin
            contagem <= 2'd0;
        end else begin
            case ({aceita, retira})
                2'b10: begin
                    if (contagem == 2'd0) begin
                        dado0 <= resultadoOp;
                        reg0  <= regDestino;
                    end else begin
                        dado1 <= resultadoOp;
                        reg1  <= regDestino;
                    end
                    contagem <= contagem + 2'd1;
                end
                2'b01: begin
                    dado0    <= dado1;
                    reg0     <= reg1;
                    contagem <= contagem - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the new one becomes the head
                    dado0 <= resultadoOp;
                    reg0  <= regDestino;
                end
                default: begin
                    contagem <= contagem;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_estagio_saida.sv
// tb_ula_estagio_saida: directed and randomized checks of the ALU output stage
// against a queue-based FIFO model and an arithmetic flag model.
module tb_ula_estagio_saida;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] operandoA, operandoB, resultadoOp;
    logic [4:0]  controle;
    logic [2:0]  regDestino;
    logic        atualizaFlags, valido_in, descarta, pronto_out;
    logic        pronto_in, valido_out;
    logic [15:0] resultado;
    logic [2:0]  regDestino_out;
    logic        flagZ, flagC, flagN, flagO;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [18:0] q[$];
    bit mz, mc, mn, mo;

    ula_estagio_saida dut (
        .clock(clock), .reset_n(reset_n),
        .operandoA(operandoA), .operandoB(operandoB), .controle(controle),
        .resultadoOp(resultadoOp), .regDestino(regDestino),
        .atualizaFlags(atualizaFlags), .valido_in(valido_in), .pronto_in(pronto_in),
        .descarta(descarta), .resultado(resultado), .regDestino_out(regDestino_out),
        .valido_out(valido_out), .pronto_out(pronto_out),
        .flagZ(flagZ), .flagC(flagC), .flagN(flagN), .flagO(flagO)
    );

    always #5 clock = ~clock;

    // Flags computed from plain integer arithmetic on the operation rules
    function automatic void model_flags(input int a, input int b, input int r, input int op,
                                        output bit z, output bit c, output bit n, output bit o);
        bit sa, sb, sr;
        sa = (a >= 32768); sb = (b >= 32768); sr = (r >= 32768);
        z = (r == 0);
        n = sr;
        case (op)
            0: c = (a + b) > 65535;
            1: c = (a + b + 1) > 65535;
            3: c = (a == 65535);
            4: c = (a + (65535 - b)) > 65535;
            5: c = (a >= b);
            6: c = (a != 0);
            8: c = sa;
            9: c = (a % 2) == 1;
            default: c = 0;
        endcase
        case (op)
            0, 1: o = (sa == sb) && (sr != sa);
            4, 5: o = (sa != sb) && (sr != sa);
            3: o = (a == 32767);
            6: o = (a == 32768);
            8: o = sa != ((a / 16384) % 2 == 1);
            default: o = 0;
        endcase
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                         input logic [15:0] r, input logic [2:0] rd, input logic af, input logic v);
        operandoA = a; operandoB = b; controle = op; resultadoOp = r;
        regDestino = rd; atualizaFlags = af; valido_in = v;
    endtask

    // Advance one clock edge, updating the model from the pre-edge inputs
    task automatic step();
        bit acc, pop;
        logic [18:0] e;
        acc = valido_in && (q.size() < 2);
        pop = (q.size() > 0) && pronto_out;
        if (acc && atualizaFlags)
            model_flags(int'(operandoA), int'(operandoB), int'(resultadoOp), int'(controle), mz, mc, mn, mo);
        if (descarta) q.delete();
        else begin
            if (pop) e = q.pop_front();
            if (acc) q.push_back({regDestino, resultadoOp});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (pronto_in !== 1'b1) begin errors++; $display("FAIL reset_pronto_in got=%b exp=1", pronto_in); end
        checks++; if (valido_out !== 1'b0) begin errors++; $display("FAIL reset_valido_out got=%b exp=0", valido_out); end
        checks++; if (resultado !== 16'h0 || regDestino_out !== 3'd0) begin errors++;
            $display("FAIL reset_data got=%h/%0d exp=0000/0", resultado, regDestino_out); end
        checks++; if ({flagZ, flagC, flagN, flagO} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags got=%b exp=0000", {flagZ, flagC, flagN, flagO}); end
    endtask

    task automatic test_add_overflow();
        pronto_out = 1'b0; descarta = 1'b0;
        drive(16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 3'd4, 1'b1, 1'b1);
        step();
        checks++; if ({flagZ, flagC, flagN, flagO} !== 4'b0011) begin errors++;
            $display("FAIL add_ovf_flags got=%b exp=0011", {flagZ, flagC, flagN, flagO}); end
        checks++; if (resultado !== 16'h8000 || valido_out !== 1'b1 || regDestino_out !== 3'd4) begin errors++;
            $display("FAIL add_ovf_out got=%h v=%b rd=%0d exp=8000 v=1 rd=4", resultado, valido_out, regDestino_out); end
        valido_in = 1'b0; pronto_out = 1'b1;
        step();
        checks++; if (valido_out !== 1'b0) begin errors++; $display("FAIL add_ovf_pop got=%b exp=0", valido_out); end
    endtask

    task automatic test_subtract();
        pronto_out = 1'b1;
        drive(16'd5, 16'd5, 5'b00101, 16'h0000, 3'd1, 1'b1, 1'b1);
        step();
        checks++; if ({flagZ, flagC, flagN, flagO} !== 4'b1100) begin errors++;
            $display("FAIL sub_zero_flags got=%b exp=1100", {flagZ, flagC, flagN, flagO}); end
        drive(16'd3, 16'd5, 5'b00101, 16'hFFFE, 3'd2, 1'b1, 1'b1);
        step();
        checks++; if ({flagZ, flagC, flagN, flagO} !== 4'b0010) begin errors++;
            $display("FAIL sub_borrow_flags got=%b exp=0010", {flagZ, flagC, flagN, flagO}); end
        checks++; if (resultado !== 16'hFFFE || regDestino_out !== 3'd2) begin errors++;
            $display("FAIL sub_head got=%h/%0d exp=fffe/2", resultado, regDestino_out); end
    endtask

    task automatic test_shifts();
        pronto_out = 1'b1;
        drive(16'hC001, 16'h0000, 5'b01000, 16'h8002, 3'd3, 1'b1, 1'b1);
        step();
        checks++; if ({flagC, flagO, flagN} !== 3'b101) begin errors++;
            $display("FAIL shl_flags got=CON %b exp=101", {flagC, flagO, flagN}); end
        drive(16'h0003, 16'h0000, 5'b01001, 16'h0001, 3'd3, 1'b1, 1'b1);
        step();
        checks++; if ({flagC, flagO} !== 2'b10) begin errors++;
            $display("FAIL shr_flags got=CO %b exp=10", {flagC, flagO}); end
        valido_in = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        pronto_out = 1'b0; descarta = 1'b0;
        drive(16'h0, 16'h0, 5'b00000, 16'h1111, 3'd1, 1'b0, 1'b1);
        step();
        checks++; if (valido_out !== 1'b1 || resultado !== 16'h1111 || pronto_in !== 1'b1) begin errors++;
            $display("FAIL bp_first got=v%b %h r%b exp=v1 1111 r1", valido_out, resultado, pronto_in); end
        drive(16'h0, 16'h0, 5'b00000, 16'h2222, 3'd2, 1'b0, 1'b1);
        step();
        checks++; if (pronto_in !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", pronto_in); end
        drive(16'h0, 16'h0, 5'b00000, 16'h3333, 3'd3, 1'b0, 1'b1);
        step();
        checks++; if (pronto_in !== 1'b0 || resultado !== 16'h1111 || regDestino_out !== 3'd1) begin errors++;
            $display("FAIL bp_hold got=r%b %h/%0d exp=r0 1111/1", pronto_in, resultado, regDestino_out); end
        valido_in = 1'b0; pronto_out = 1'b1;
        step();
        checks++; if (resultado !== 16'h2222 || regDestino_out !== 3'd2 || pronto_in !== 1'b1) begin errors++;
            $display("FAIL bp_second got=%h/%0d r%b exp=2222/2 r1", resultado, regDestino_out, pronto_in); end
        step();
        checks++; if (valido_out !== 1'b0) begin errors++;
            $display("FAIL bp_drop_third got=%b exp=0", valido_out); end
    endtask

    task automatic test_flag_hold_flush();
        pronto_out = 1'b0; descarta = 1'b0;
        drive(16'd1, 16'd2, 5'b00000, 16'd3, 3'd5, 1'b1, 1'b1);
        step();
        drive(16'd0, 16'd0, 5'b00000, 16'd0, 3'd6, 1'b0, 1'b1);
        step();
        checks++; if (flagZ !== 1'b0) begin errors++; $display("FAIL hold_z got=%b exp=0", flagZ); end
        checks++; if (pronto_in !== 1'b0 || valido_out !== 1'b1) begin errors++;
            $display("FAIL hold_full got=r%b v%b exp=r0 v1", pronto_in, valido_out); end
        valido_in = 1'b0; descarta = 1'b1;
        step();
        checks++; if (valido_out !== 1'b0 || pronto_in !== 1'b1) begin errors++;
            $display("FAIL flush_empty got=v%b r%b exp=v0 r1", valido_out, pronto_in); end
        checks++; if ({flagZ, flagC, flagN, flagO} !== 4'b0000) begin errors++;
            $display("FAIL flush_flags got=%b exp=0000", {flagZ, flagC, flagN, flagO}); end
        // Flagged accept in a flush cycle: flags load, entry is dropped
        drive(16'h8000, 16'h8000, 5'b00000, 16'h0000, 3'd7, 1'b1, 1'b1);
        step();
        checks++; if ({flagZ, flagC, flagN, flagO} !== 4'b1101 || valido_out !== 1'b0) begin errors++;
            $display("FAIL flush_accept got=%b v%b exp=1101 v0", {flagZ, flagC, flagN, flagO}, valido_out); end
        descarta = 1'b0; valido_in = 1'b0;
    endtask

    task automatic test_random();
        int ops[10] = '{0, 1, 3, 4, 5, 6, 8, 9, 2, 15};
        logic [15:0] edges[6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'hC000};
        logic [15:0] a, b, r;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
            r = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            drive(a, b, 5'(($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : ops[$urandom_range(0, 9)]),
                  r, 3'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
            descarta   = ($urandom_range(0, 15) == 0);
            pronto_out = 1'($urandom);
            step();
            checks++;
            if (valido_out !== (q.size() > 0) || pronto_in !== (q.size() < 2) ||
                (q.size() > 0 && {regDestino_out, resultado} !== q[0]) ||
                {flagZ, flagC, flagN, flagO} !== {mz, mc, mn, mo}) begin
                errors++;
                $display("FAIL random[%0d] got=v%b r%b %0d/%h zcno=%b exp=v%b r%b %h zcno=%b", i,
                         valido_out, pronto_in, regDestino_out, resultado, {flagZ, flagC, flagN, flagO},
                         q.size() > 0, q.size() < 2, (q.size() > 0) ? q[0] : 19'h0, {mz, mc, mn, mo});
            end
        end
        descarta = 1'b0; valido_in = 1'b0;
    endtask

    task automatic test_async_reset();
        pronto_out = 1'b0; descarta = 1'b0;
        drive(16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 3'd6, 1'b1, 1'b1);
        step();
        valido_in = 1'b0;
        checks++; if (valido_out !== 1'b1 || flagN !== 1'b1) begin errors++;
            $display("FAIL areset_pre got=v%b n%b exp=v1 n1", valido_out, flagN); end
        #2 reset_n = 1'b0;
        #1;
        q.delete(); mz = 0; mc = 0; mn = 0; mo = 0;
        checks++; if (valido_out !== 1'b0 || resultado !== 16'h0 || regDestino_out !== 3'd0 ||
                      {flagZ, flagC, flagN, flagO} !== 4'b0000) begin errors++;
            $display("FAIL areset_now got=v%b %h/%0d %b exp=v0 0000/0 0000", valido_out, resultado,
                     regDestino_out, {flagZ, flagC, flagN, flagO}); end
        #2 reset_n = 1'b1;
        #1;
        checks++; if (pronto_in !== 1'b1) begin errors++; $display("FAIL areset_release got=%b exp=1", pronto_in); end
    endtask

    initial begin
        reset_n = 1'b0; descarta = 1'b0; pronto_out = 1'b0;
        drive(16'h0, 16'h0, 5'b0, 16'h0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        test_reset();
        test_add_overflow();
        test_subtract();
        test_shifts();
        test_backpressure();
        test_flag_hold_flush();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ula_estagio_saida.md
# ula_estagio_saida

ALU output stage sitting directly downstream of the 16-bit combinational ALU. It captures each ALU result together with its operands and control code, and computes the Z/C/N/O status flags that the ALU itself does not produce. Results are buffered in a 2-entry FIFO toward the register-file writeback port under a valid/ready handshake. The flags are held in an architectural status register.

## Interface
Parameters:
- `bits_palavra`, 16: data word width.
- `bits_controle`, 5: ALU control code width.
- `bits_reg`, 3: destination register index width.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `operandoA` in `bits_palavra`: ALU operand A, signed.
- `operandoB` in `bits_palavra`: ALU operand B, signed.
- `controle` in `bits_controle`: ALU operation code, same encoding as the ALU.
- `resultadoOp` in `bits_palavra`: ALU result.
- `regDestino` in `bits_reg`: destination register index.
- `atualizaFlags` in 1: the operation updates the status register.
- `valido_in` in 1: upstream transaction valid.
- `pronto_in` out 1: stage can accept a transaction.
- `descarta` in 1: synchronous flush of buffered results.
- `resultado` out `bits_palavra`: head-of-FIFO result.
- `regDestino_out` out `bits_reg`: head-of-FIFO destination.
- `valido_out` out 1: head-of-FIFO valid.
- `pronto_out` in 1: writeback accepts the head entry.
- `flagZ`, `flagC`, `flagN`, `flagO` out 1 each: status register outputs.

## Operation
- Accept: `valido_in && pronto_in` at a rising edge. The entry {`resultadoOp`, `regDestino`} is pushed into the FIFO.
- Flag update: on accept with `atualizaFlags`=1, the status register loads the computed flags. With `atualizaFlags`=0 the flags hold. `descarta` never touches the flags.
- Z = (`resultadoOp` == 0). N = `resultadoOp`[15].
- C is computed with 17-bit unsigned arithmetic on the operands:
  - 00000: carry of A+B.
  - 00001: carry of A+B+1.
  - 00011: carry of A+1, i.e. A==16'hFFFF.
  - 00101: carry of A+~B+1, i.e. 1 when A≥B unsigned.
  - 00100: carry of A+~B.
  - 00110: carry of A+16'hFFFF, i.e. A≠0.
  - 01000: A[15].
  - 01001: A[0].
  - All other codes: 0.
- O:
  - Add codes (00000, 00001): A[15]==B[15] && R[15]≠A[15].
  - Subtract codes (00100, 00101): A[15]≠B[15] && R[15]≠A[15].
  - 00011: A==16'h7FFF.
  - 00110: A==16'h8000.
  - 01000: A[15]^A[14].
  - All other codes: 0.
- FIFO:
  - Depth 2, entries kept in order.
  - Pop on `valido_out && pronto_out`.
  - `pronto_in` = (count < 2). It does not depend on `pronto_out` in the same cycle (no combinational ready path).
- Simultaneous push and pop: count unchanged. The new entry goes behind the remaining one, or becomes the head when count was 1.
- Flush: `descarta`=1 sets count to 0. It overrides any push or pop in the same cycle. A flagged transaction accepted in that same cycle still updates the flags.
- Reset: count=0, `valido_out`=0, `resultado`=0, `regDestino_out`=0, all flags 0. `pronto_in`=1 once reset is released.

## Timing
- Latency: a transaction accepted at edge k is on `resultado`/`valido_out` after edge k, provided the FIFO was empty.
- Flags are visible after the accepting edge k.
- Outputs are registered or derived from FIFO state only. The only combinational input-to-output paths go into the flag next-state logic.
- Throughput: one transaction per cycle while `pronto_out`=1 continuously.
- Full: count=2 → `pronto_in`=0 for that cycle. It returns to 1 the cycle after a pop.
- Head stable: `resultado`/`regDestino_out` hold while `valido_out`=1 and `pronto_out`=0.
- Reset asserted mid-operation: the FIFO empties and the flags clear immediately (asynchronous). In-flight entries are lost.

## Test plan
- Add overflow: A=16'h7FFF, B=16'h0001, controle=00000, R=16'h8000, atualizaFlags=1 → Z=0 C=0 N=1 O=1 after the edge. `resultado`=16'h8000, `valido_out`=1.
- Subtract zero/borrow: A=5, B=5, controle=00101, R=0 → Z=1 C=1 N=0 O=0. Then A=3, B=5, R=16'hFFFE → Z=0 C=0 N=1 O=0.
- Shifts: A=16'hC001, controle=01000, R=16'h8002 → C=1 O=0 N=1. Then A=16'h0003, controle=01001, R=1 → C=1 O=0.
- Backpressure: `pronto_out`=0, push 3 valid transactions → `pronto_in`=0 after the second push and the third is not accepted. Then `pronto_out`=1 → first and second pop in order, and `pronto_in`=1 again.
- Flag hold and flush: a flagged add is followed by an op with `atualizaFlags`=0 and R=0 → Z is unchanged. Asserting `descarta` with count=2 → `valido_out`=0 next cycle and the flags are unchanged.
- Asynchronous reset: assert `reset_n`=0 between edges with count=1 and flags set → all outputs 0 immediately, without waiting for a clock edge.
